cpu_sequencer: RTL

- Multi-cycle sequencer for the 8-bit processor datapath.
- Steps each instruction through fetch, decode, memory/IO access and writeback.
- Shares the single memory port between instruction fetch and data loads/stores.
- Consumes the strobes of the combinational control decoder and produces gated, cycle-correct enables, with a wait timeout, halt and fault handling.

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/wait_timer.sv | 40 ++++
 rtl/cpu_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the multi-cycle CPU sequencer.
//   state_t   : sequencer state encoding (also exported on state_o for debug)
//   strobes_t : decoder strobes captured during DECODE
//   TIMEOUT_DEFAULT : default wait-state limit before a FAULT
//   is_illegal() : flags mutually exclusive strobe combinations
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_IO     = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    typedef struct packed {
        logic we;
        logic st_pc;
        logic store_flags;
        logic ram_ld;
        logic ram_st;
        logic io_r;
        logic io_w;
        logic halt;
    } strobes_t;

    // An instruction may touch at most one of RAM-read, RAM-write, IO-read,
    // IO-write; anything else is an illegal encoding.
    function automatic logic is_illegal(input strobes_t s);
        return (s.ram_ld & s.ram_st)
             | ((s.ram_ld | s.ram_st) & (s.io_r | s.io_w))
             | (s.io_r & s.io_w);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts stalled cycles of a wait state and flags the cycle on which the
// stall limit is reached.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : clear the count (state is not waiting, or the access ends)
//   i_en        : this cycle is a stalled wait cycle
//   o_expired   : this stalled cycle is the TIMEOUT-th one
// -----------------------------------------------------------------------------
module wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TO_W-1:0] r_cnt;

    // r_cnt holds the number of stalled cycles already seen, so the current
    // stalled cycle is number r_cnt+1.
    assign o_expired = i_en && (r_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
// Multi-cycle sequencer for the 8-bit datapath: FETCH -> DECODE ->
// [MEM | IO] -> WB, sharing one memory port between fetch and data access.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   run                   : permit leaving IDLE / continuing after WB
//   dec_*                 : combinational decoder strobes, valid in DECODE
//   mem_ready, io_ack     : access completion from memory / IO device
//   mem_req/mem_we/addr_sel : memory port control (addr_sel 0=PC, 1=data)
//   ir_load               : latch fetched word (FETCH & mem_ready)
//   io_req/io_we          : IO port control
//   rf_we/flags_en/pc_en/pc_load : writeback pulses
//   halted/fault          : sticky status, cleared only by reset
//   state_o               : current state for debug
//   retired               : retired-instruction count, wraps
// Handshake: a request (mem_req or io_req) rises on entry to its state and
// stays high and stable until the cycle in which mem_ready / io_ack is seen
// high; that cycle completes the access and the state advances on its edge.
// -----------------------------------------------------------------------------
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             dec_we,
    input  logic             dec_st_pc,
    input  logic             dec_store_flags,
    input  logic             dec_ram_ld,
    input  logic             dec_ram_st,
    input  logic             dec_io_r,
    input  logic             dec_io_w,
    input  logic             dec_halt,
    input  logic             mem_ready,
    input  logic             io_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_load,
    output logic             io_req,
    output logic             io_we,
    output logic             rf_we,
    output logic             flags_en,
    output logic             pc_en,
    output logic             pc_load,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    strobes_t         r_strb;
    logic [CNT_W-1:0] r_retired;
    logic             r_mem_req, r_mem_we, r_addr_sel;
    logic             r_io_req, r_io_we;
    logic             r_rf_we, r_flags_en, r_pc_en, r_pc_load;
    logic             r_halted, r_fault;

    state_t           w_state_nxt;
    strobes_t         w_dec;
    strobes_t         w_strb_nxt;
    logic             w_waiting;
    logic             w_done;
    logic             w_expired;

    assign w_dec = '{we: dec_we, st_pc: dec_st_pc, store_flags: dec_store_flags,
                     ram_ld: dec_ram_ld, ram_st: dec_ram_st,
                     io_r: dec_io_r, io_w: dec_io_w, halt: dec_halt};

    // Strobes are captured only on the DECODE edge and held for MEM/IO/WB.
    assign w_strb_nxt = (r_state == ST_DECODE) ? w_dec : r_strb;

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM) || (r_state == ST_IO);
    assign w_done    = (((r_state == ST_FETCH) || (r_state == ST_MEM)) && mem_ready)
                     || ((r_state == ST_IO) && io_ack);

    // Clearing whenever not stalled means every entry to a wait state
    // starts from zero; completion on the limit cycle suppresses expiry.
    wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_waiting || w_done),
        .i_en      (w_waiting && !w_done),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)      w_state_nxt = ST_DECODE;
                else if (w_expired) w_state_nxt = ST_FAULT;
            end
            ST_DECODE: begin
                if (w_dec.halt)                       w_state_nxt = ST_HALT;
                else if (is_illegal(w_dec))           w_state_nxt = ST_FAULT;
                else if (w_dec.ram_ld | w_dec.ram_st) w_state_nxt = ST_MEM;
                else if (w_dec.io_r | w_dec.io_w)     w_state_nxt = ST_IO;
                else                                  w_state_nxt = ST_WB;
            end
            ST_MEM: begin
                if (mem_ready)      w_state_nxt = ST_WB;
                else if (w_expired) w_state_nxt = ST_FAULT;
            end
            ST_IO: begin
                if (io_ack)         w_state_nxt = ST_WB;
                else if (w_expired) w_state_nxt = ST_FAULT;
            end
            ST_WB:     w_state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:   w_state_nxt = ST_HALT;
            ST_FAULT:  w_state_nxt = ST_FAULT;
            default:   w_state_nxt = ST_FAULT;
        endcase
    end

    // Outputs are registered from the next state and next strobes, so each
    // is a Moore decode of the state it is visible in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_strb     <= '0;
            r_retired  <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr_sel <= 1'b0;
            r_io_req   <= 1'b0;
            r_io_we    <= 1'b0;
            r_rf_we    <= 1'b0;
            r_flags_en <= 1'b0;
            r_pc_en    <= 1'b0;
            r_pc_load  <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_strb     <= w_strb_nxt;
            if (r_state == ST_WB) r_retired <= r_retired + 1'b1;
            r_mem_req  <= (w_state_nxt == ST_FETCH)
                       || ((w_state_nxt == ST_MEM) && (w_strb_nxt.ram_ld | w_strb_nxt.ram_st));
            r_mem_we   <= (w_state_nxt == ST_MEM) && w_strb_nxt.ram_st;
            r_addr_sel <= (w_state_nxt == ST_MEM);
            r_io_req   <= (w_state_nxt == ST_IO) && (w_strb_nxt.io_r | w_strb_nxt.io_w);
            r_io_we    <= (w_state_nxt == ST_IO) && w_strb_nxt.io_w;
            r_rf_we    <= (w_state_nxt == ST_WB) && w_strb_nxt.we;
            r_flags_en <= (w_state_nxt == ST_WB) && w_strb_nxt.store_flags;
            r_pc_en    <= (w_state_nxt == ST_WB);
            r_pc_load  <= (w_state_nxt == ST_WB) && w_strb_nxt.st_pc;
            r_halted   <= (w_state_nxt == ST_HALT) && w_strb_nxt.halt;
            r_fault    <= (w_state_nxt == ST_FAULT);
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign addr_sel = r_addr_sel;
    assign ir_load  = (r_state == ST_FETCH) && r_mem_req && mem_ready;
    assign io_req   = r_io_req;
    assign io_we    = r_io_we;
    assign rf_we    = r_rf_we;
    assign flags_en = r_flags_en;
    assign pc_en    = r_pc_en;
    assign pc_load  = r_pc_load;
    assign halted   = r_halted;
    assign fault    = r_fault;
    assign state_o  = r_state;
    assign retired  = r_retired;

endmodule
